ram_hs_sync: RTL and testbench



---
 rtl/ram_hs_sync.sv | 144 ++++++++++++++
 tb/tb_ram_hs_sync.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_hs_sync.sv
// Byte-addressable big-endian RAM with mov/moc four-phase handshake.
// Define RAM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module ram_hs_sync #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  typeData,
  input  logic [31:0] address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        moc,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              rw_q;
  logic [1:0]        td_q;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [31:0]       din_q;
  logic [3:0]        cnt;
  logic              go;
  logic              misal;
  logic              bad;
  logic [31:0]       rd;
  logic              unused_addr;

  logic [7:0] mem [2**ADDR_W];

  assign unused_addr = ^address[31:ADDR_W];

  // wraps modulo the RAM depth by construction
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

`ifdef RAM_ALIGN_CHECK_EN
  assign misal = ((td_q == 2'b01) && a0[0]) ||
                 ((td_q == 2'b10) && (a0[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign bad = (td_q == 2'b11) || misal;

  always_comb begin
    rd = 32'h0;
    case (td_q)
      2'b00:   rd = {24'h0, mem[a0]};
      2'b01:   rd = {16'h0, mem[a0], mem[a1]};
      2'b10:   rd = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    unique case (state)
      IDLE: if (mov) state_nx = BUSY;
      BUSY: begin
        if (cnt == 4'd0) begin
          go       = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: if (!mov) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q  <= 1'b0;
      td_q  <= 2'b00;
      a0    <= '0;
      din_q <= 32'h0;
      cnt   <= 4'd0;
    end else if (state == IDLE && mov) begin
      rw_q  <= rw;
      td_q  <= typeData;
      a0    <= address[ADDR_W-1:0];
      din_q <= DataIn;
      cnt   <= 4'(LATENCY - 1);
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt   <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      moc     <= 1'b0;
      err     <= 1'b0;
      DataOut <= 32'h0;
    end else if (go) begin
      moc <= 1'b1;
      err <= bad;
      if (rw_q && !bad) DataOut <= rd;
    end else if (state == DONE && !mov) begin
      moc <= 1'b0;
      err <= 1'b0;
    end
  end

  // array is deliberately left without reset
  always_ff @(posedge clk) begin
    if (!reset && go && !rw_q && !bad) begin
      case (td_q)
        2'b00: mem[a0] <= din_q[7:0];
        2'b01: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        2'b10: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_hs_sync.sv
// Directed bench for ram_hs_sync (ADDR_W=8, LATENCY=3).
// Expectations follow RAM_ALIGN_CHECK_EN when it is defined.
module tb_ram_hs_sync;

  localparam int AW  = 8;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mov = 1'b0;
  logic        rw = 1'b1;
  logic [1:0]  typeData = 2'b00;
  logic [31:0] address = 32'h0;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] DataOut;
  logic        moc;
  logic        err;

  int n_run = 0;
  int n_fail = 0;

  ram_hs_sync #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .mov(mov),
    .rw(rw),
    .typeData(typeData),
    .address(address),
    .DataIn(DataIn),
    .DataOut(DataOut),
    .moc(moc),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_acc(input logic r, input logic [1:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output logic [31:0] q,
                        output logic e, output int lat);
    @(negedge clk);
    mov = 1'b1;
    rw = r;
    typeData = t;
    address = a;
    DataIn = d;
    @(posedge clk);
    @(negedge clk);
    if (!keep) mov = 1'b0;
    rw = ~r;
    typeData = t ^ 2'b01;
    address = $urandom;
    DataIn = $urandom;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (moc) break;
    end
    q = DataOut;
    e = err;
    if (!keep) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] q;
    logic e;
    int lat;
    int cnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_moc", {31'h0, moc}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_dout", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_acc(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, q, e, lat);
    chk("wr_w_lat", lat, LAT);
    chk("wr_w_err", {31'h0, e}, 32'h0);
    chk("wr_keeps_dout", q, 32'h0);

    do_acc(1'b1, 2'b00, 32'h10, 32'h0, 1'b0, q, e, lat);
    chk("rd_b10", q, 32'hDE);
    chk("rd_b10_lat", lat, LAT);
    do_acc(1'b1, 2'b00, 32'hFFFF_FF11, 32'h0, 1'b0, q, e, lat);
    chk("rd_b11_hiaddr", q, 32'hAD);
    do_acc(1'b1, 2'b00, 32'h12, 32'h0, 1'b0, q, e, lat);
    chk("rd_b12", q, 32'hBE);
    do_acc(1'b1, 2'b00, 32'h13, 32'h0, 1'b0, q, e, lat);
    chk("rd_b13", q, 32'hEF);

    do_acc(1'b0, 2'b01, 32'h20, 32'hFFFF1234, 1'b0, q, e, lat);
    do_acc(1'b1, 2'b01, 32'h20, 32'h0, 1'b0, q, e, lat);
    chk("rd_h20", q, 32'h00001234);
    chk("rd_h20_err", {31'h0, e}, 32'h0);
    do_acc(1'b1, 2'b10, 32'h20, 32'h0, 1'b0, q, e, lat);
    chk("rd_w20_hi", {16'h0, q[31:16]}, 32'h1234);

    do_acc(1'b0, 2'b10, 32'hFE, 32'hA1B2C3D4, 1'b0, q, e, lat);
`ifdef RAM_ALIGN_CHECK_EN
    chk("wrap_w_err", {31'h0, e}, 32'h1);
    chk("wrap_w_lat", lat, LAT);
`else
    chk("wrap_w_err", {31'h0, e}, 32'h0);
    do_acc(1'b1, 2'b00, 32'h00, 32'h0, 1'b0, q, e, lat);
    chk("wrap_b00", q, 32'hC3);
    do_acc(1'b1, 2'b00, 32'h01, 32'h0, 1'b0, q, e, lat);
    chk("wrap_b01", q, 32'hD4);
    do_acc(1'b1, 2'b10, 32'hFE, 32'h0, 1'b0, q, e, lat);
    chk("wrap_wFE", q, 32'hA1B2C3D4);
`endif

    do_acc(1'b0, 2'b00, 32'h05, 32'h77, 1'b0, q, e, lat);
    do_acc(1'b0, 2'b10, 32'h05, 32'h11223344, 1'b0, q, e, lat);
`ifdef RAM_ALIGN_CHECK_EN
    chk("mis_err", {31'h0, e}, 32'h1);
    do_acc(1'b1, 2'b00, 32'h05, 32'h0, 1'b0, q, e, lat);
    chk("mis_b05", q, 32'h77);
`else
    chk("mis_err", {31'h0, e}, 32'h0);
    do_acc(1'b1, 2'b00, 32'h05, 32'h0, 1'b0, q, e, lat);
    chk("mis_b05", q, 32'h11);
    do_acc(1'b1, 2'b00, 32'h08, 32'h0, 1'b0, q, e, lat);
    chk("mis_b08", q, 32'h44);
`endif

    do_acc(1'b1, 2'b00, 32'h12, 32'h0, 1'b0, q, e, lat);
    do_acc(1'b1, 2'b11, 32'h10, 32'h0, 1'b0, q, e, lat);
    chk("rsv_err", {31'h0, e}, 32'h1);
    chk("rsv_dout", q, 32'hBE);
    chk("rsv_lat", lat, LAT);
    chk("rsv_err_clr", {31'h0, err}, 32'h0);

    do_acc(1'b0, 2'b00, 32'h30, 32'hAA, 1'b0, q, e, lat);
    @(negedge clk);
    mov = 1'b1;
    rw = 1'b0;
    typeData = 2'b00;
    address = 32'h30;
    DataIn = 32'h55;
    @(posedge clk);
    @(negedge clk);
    mov = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_moc", {31'h0, moc}, 32'h0);
    chk("abort_dout", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (moc !== 1'b0) cnt++;
    end
    chk("abort_no_moc", cnt, 0);
    do_acc(1'b1, 2'b00, 32'h30, 32'h0, 1'b0, q, e, lat);
    chk("abort_mem", q, 32'hAA);

    do_acc(1'b1, 2'b00, 32'h11, 32'h0, 1'b1, q, e, lat);
    chk("hold_lat", lat, LAT);
    chk("hold_data", q, 32'hAD);
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (moc !== 1'b1) cnt++;
    end
    chk("hold_moc", cnt, 0);
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_drop", {31'h0, moc}, 32'h0);
    do_acc(1'b1, 2'b00, 32'h12, 32'h0, 1'b0, q, e, lat);
    chk("next_lat", lat, LAT);
    chk("next_data", q, 32'hBE);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
